divider_scheduler: RTL
======================

# divider_scheduler

Shares one free-running power-of-two prescaler counter among `Channels` independent tick channels. Each channel is programmed over a valid/ready config port with a divide exponent and an optional tick count. It then emits single-cycle `tick` strobes at period 2^power, phase-aligned to the shared counter. The block sits between the frame/pixel sequencing logic and the rate-dependent datapaths, replacing per-consumer dividers with one counter plus scheduling.

## Interface
- `Channels`, 4: number of tick channels (1..16).
- `CounterWidth`, 16: shared counter width; maximum exponent.
- `CountWidth`, 8: width of the per-channel tick-count field.
- `PW` (localparam), $clog2(CounterWidth+1): exponent field width.

- `clk_in`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config accept (registered).
- `cfg_chan`  in  $clog2(Channels) (min 1)  target channel.
- `cfg_power`  in  PW  exponent 1..CounterWidth; 0 = stop channel.
- `cfg_count`  in  CountWidth  ticks to emit, then stop; 0 = continuous.
- `cfg_err`  out  1  one-cycle pulse: bad `cfg_chan`, or `cfg_power` > CounterWidth.
- `tick`  out  Channels  per-channel one-cycle strobe.
- `done`  out  Channels  per-channel one-cycle pulse on burst completion.
- `active`  out  Channels  channel is ARM or RUN.

## Operation
- Shared counter `cnt` resets to 0 and increments every cycle, wrapping modulo 2^CounterWidth. Wrap is seamless; no missed or extra matches.
- A channel with exponent p matches in any cycle where cnt[p-1:0] == 2^(p-1). The top bit of the slice is 1 and the lower bits are 0. Match period is 2^p. For p=1, odd cnt values match.
- Accept: `cfg_valid & cfg_ready` at a rising edge. `cfg_ready` stays 1 whenever out of reset. There is no back-pressure.
- Per-channel FSM with states IDLE, ARM, RUN:
  - IDLE → ARM: accepted config with power 1..CounterWidth. Latch p; load `remaining` = `cfg_count`.
  - ARM → RUN: first match. Emit tick.
  - RUN: each match emits a tick. If `remaining` == 1 at the tick, emit `done`, go to IDLE. If `remaining` > 1, decrement. If `remaining` == 0 (continuous), hold.
  - Any state, power = 0 config → IDLE. No tick, no `done`.
  - ARM/RUN, new valid config → ARM with the new p and count. The old burst is abandoned without `done`.
- Invalid config (chan ≥ Channels, or power > CounterWidth): `cfg_err` pulses. No channel state changes.
- Simultaneous events:
  - A config to a channel in the same cycle as its match: config wins. No tick, no `done` from the old setting.
  - Configs to different channels are independent.
- `active` = state ≠ IDLE. It is registered and goes low in the same cycle `done` pulses.

## Timing
- Reset (async assert): `cnt` = 0, all channels IDLE. `tick`, `done`, `active`, `cfg_err`, `cfg_ready` = 0.
- Cycle 0 is the first cycle with `rst_n` high: `cnt` = 0 and `cfg_ready` = 0. `cfg_ready` = 1 from cycle 1.
- `cnt` = k in cycle k, modulo 2^CounterWidth.
- Config accepted in cycle c: the channel is ARM in cycle c+1. Matches count from cycle c+1 onward.
- Match in cycle m: `tick` high in cycle m+1. Final-tick `done` is high in the same cycle as that tick.
- `cfg_err` is high in cycle c+1 for an invalid config accepted in cycle c.
- Reset mid-burst: outputs clear immediately. No `done` is generated.

## Configuration
- `DIVSCHED_BURST_EN` defined: `cfg_count` and the `remaining` counters exist. Finite bursts and `done` behave as above.
- Not defined: `cfg_count` is ignored, no `remaining` registers are built, all channels run continuously, and `done` is tied to 0.

## Test plan
- Reset release, write ch0 p=2 count=0 in cycle 1 → ch0 `tick` in cycles 3, 7, 11, …; `active[0]` from cycle 2.
- ch1 p=3 count=2 written in cycle 1 (BURST_EN) → ticks in cycles 5 and 13; `done[1]` in cycle 13; `active[1]` low from cycle 13; no further ticks.
- ch0 running p=2; write p=0 in the cycle where cnt=6 → no tick in cycle 7; `active[0]` low in cycle 7.
- Write cfg_chan=Channels or power=CounterWidth+1 → `cfg_err` one cycle; all `tick`/`active` unchanged.
- p=CounterWidth=16 continuous → ticks at cnt 32768+1 and 98304+1 in successive periods, continuing across the counter wrap.
- Pull `rst_n` low while ch2 is in RUN → `tick`, `done`, `active` all 0 at once; after release ch2 stays IDLE with no ticks.

Source files
------------

// File: rtl/divider_scheduler.sv
// rtl/divider_scheduler.sv - shared power-of-two prescaler with per-channel tick scheduling
//
// One free-running counter (cnt) is shared by all channels. A channel with
// exponent p matches whenever cnt[p-1:0] == 2^(p-1), giving a 2^p period that
// is phase-aligned across every channel using the same p.
//
// Optional feature macro: DIVSCHED_BURST_EN (finite bursts, remaining counters, done).
//
// Ports:
//   clk_in     clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_valid  config request
//   cfg_ready  config accept, registered, 1 from the second cycle after reset
//   cfg_chan   target channel
//   cfg_power  divide exponent 1..CounterWidth, 0 stops the channel
//   cfg_count  ticks per burst, 0 = continuous (ignored without burst support)
//   cfg_err    one-cycle pulse for an out-of-range channel or exponent
//   tick       per-channel one-cycle strobe
//   done       per-channel one-cycle pulse on the final tick of a burst
//   active     per-channel, channel is ARM or RUN
module divider_scheduler #(
  parameter int Channels     = 4,
  parameter int CounterWidth = 16,
  parameter int CountWidth   = 8,
  localparam int PW          = $clog2(CounterWidth + 1),
  localparam int CW          = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CW-1:0]         cfg_chan,
  input  logic [PW-1:0]         cfg_power,
  input  logic [CountWidth-1:0] cfg_count,
  output logic                  cfg_err,
  output logic [Channels-1:0]   tick,
  output logic [Channels-1:0]   done,
  output logic [Channels-1:0]   active
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam logic [CW:0]   ChanLimit = (CW + 1)'(Channels);
  localparam logic [PW-1:0] PowerMax  = PW'(CounterWidth);

  logic [CounterWidth-1:0] cnt;
  state_t                  state_q [Channels];
  logic [PW-1:0]           pw_q    [Channels];
  logic [Channels-1:0]     match;
  logic                    cfg_fire;
  logic                    cfg_bad;

`ifdef DIVSCHED_BURST_EN
  logic [CountWidth-1:0]   rem_q   [Channels];
`else
  logic                    unused_count;
  assign unused_count = ^cfg_count;
  assign done = '0;
`endif

  // True when the low p bits of c are exactly 100..0.
  function automatic logic is_match(input logic [CounterWidth-1:0] c,
                                    input logic [PW-1:0] p);
    logic [CounterWidth:0] one;
    logic [CounterWidth:0] mask;
    logic [CounterWidth:0] half;
    one  = {{CounterWidth{1'b0}}, 1'b1};
    mask = (one << p) - one;
    half = one << (p - 1'b1);
    return (({1'b0, c} & mask) == half);
  endfunction

  assign cfg_fire = cfg_valid & cfg_ready;
  assign cfg_bad  = ({1'b0, cfg_chan} >= ChanLimit) | (cfg_power > PowerMax);

  always_comb begin
    match = '0;
    for (int i = 0; i < Channels; i++) begin
      match[i] = (state_q[i] != IDLE) && is_match(cnt, pw_q[i]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      tick      <= '0;
      active    <= '0;
`ifdef DIVSCHED_BURST_EN
      done      <= '0;
`endif
      for (int i = 0; i < Channels; i++) begin
        state_q[i] <= IDLE;
        pw_q[i]    <= '0;
`ifdef DIVSCHED_BURST_EN
        rem_q[i]   <= '0;
`endif
      end
    end else begin
      cnt       <= cnt + 1'b1;
      cfg_ready <= 1'b1;
      cfg_err   <= cfg_fire & cfg_bad;
      for (int i = 0; i < Channels; i++) begin
        tick[i] <= 1'b0;
`ifdef DIVSCHED_BURST_EN
        done[i] <= 1'b0;
`endif
        // A config to this channel overrides any match from the old setting.
        if (cfg_fire && !cfg_bad && (cfg_chan == CW'(i))) begin
          if (cfg_power == '0) begin
            state_q[i] <= IDLE;
            active[i]  <= 1'b0;
          end else begin
            state_q[i] <= ARM;
            pw_q[i]    <= cfg_power;
            active[i]  <= 1'b1;
`ifdef DIVSCHED_BURST_EN
            rem_q[i]   <= cfg_count;
`endif
          end
        end else if (match[i]) begin
          tick[i]    <= 1'b1;
          state_q[i] <= RUN;
`ifdef DIVSCHED_BURST_EN
          // The first tick out of ARM counts toward the burst as well.
          if (rem_q[i] == CountWidth'(1)) begin
            done[i]    <= 1'b1;
            state_q[i] <= IDLE;
            active[i]  <= 1'b0;
          end else if (rem_q[i] != '0) begin
            rem_q[i] <= rem_q[i] - 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule
